// File: rtl/cpu_ad48_irq_ctrl.sv
// Platform interrupt controller feeding the cpu_ad48 irq[] lines: edge/level pending
// capture, fixed-priority claim/complete over a 48-bit register port.
module cpu_ad48_irq_ctrl #(
  parameter int NUM_SRC   = 8,
  parameter int IRQ_LINES = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_SRC-1:0]   src_i,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [2:0]           req_addr,
  input  logic [47:0]          req_wdata,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [47:0]          rsp_rdata,
  output logic [IRQ_LINES-1:0] irq
);

  localparam logic [2:0] A_PEND = 3'd0, A_EN = 3'd1, A_TRIG = 3'd2,
                         A_CLAIM = 3'd3, A_INSVC = 3'd4, A_SWSET = 3'd5;

  logic [NUM_SRC-1:0]   r_pend, r_en, r_trig, r_insvc, r_src_q;
  logic [IRQ_LINES-1:0] r_irq;
  logic                 r_rsp_valid;
  logic [47:0]          r_rsp_rdata;

  logic [NUM_SRC-1:0]   w_elig, w_claim_oh, w_claim_take, w_cmp_oh, w_sw, w_edge;
  logic [NUM_SRC-1:0]   w_pend_edge, w_pend_d, w_insvc_d;
  logic [47:0]          w_claim_val, w_rdata;
  logic [IRQ_LINES-1:0] w_irq_d;
  logic                 w_wr, w_rd;

  function automatic logic [NUM_SRC-1:0] line_mask(input int l);
    logic [NUM_SRC-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_SRC; i++) m[i] = ((i % IRQ_LINES) == l);
    return m;
  endfunction

  assign w_wr   = req_valid & req_we;
  assign w_rd   = req_valid & ~req_we;
  assign w_elig = r_pend & r_en & ~r_insvc;
  assign w_edge = src_i & ~r_src_q;

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    w_claim_oh  = '0;
    w_claim_val = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_claim_oh    = '0;
        w_claim_oh[i] = 1'b1;
        w_claim_val   = 48'(i + 1);
      end
    end
  end

  always_comb begin
    w_cmp_oh = '0;
    for (int i = 0; i < NUM_SRC; i++)
      w_cmp_oh[i] = w_wr && (req_addr == A_CLAIM) && (req_wdata == 48'(i + 1)) && r_insvc[i];
  end

  assign w_claim_take = (w_rd && req_addr == A_CLAIM) ? w_claim_oh : '0;
  assign w_sw         = (w_wr && req_addr == A_SWSET) ? (req_wdata[NUM_SRC-1:0] & r_trig) : '0;
  // A fresh edge or SWSET overrides the claim clear on the same edge.
  assign w_pend_edge  = (r_pend & ~w_claim_take) | w_edge | w_sw;
  assign w_pend_d     = (r_trig & w_pend_edge) | (~r_trig & src_i);
  assign w_insvc_d    = (r_insvc | w_claim_take) & ~w_cmp_oh;

  always_comb begin
    w_rdata = '0;
    case (req_addr)
      A_PEND:  w_rdata = 48'(r_pend);
      A_EN:    w_rdata = 48'(r_en);
      A_TRIG:  w_rdata = 48'(r_trig);
      A_CLAIM: w_rdata = w_claim_val;
      A_INSVC: w_rdata = 48'(r_insvc);
      default: w_rdata = '0;
    endcase
  end

  for (genvar l = 0; l < IRQ_LINES; l++) begin : g_line
    localparam logic [NUM_SRC-1:0] MASK = line_mask(l);
    assign w_irq_d[l] = |(w_elig & MASK);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pend      <= '0;
      r_en        <= '0;
      r_trig      <= '0;
      r_insvc     <= '0;
      r_src_q     <= '0;
      r_irq       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_src_q     <= src_i;
      r_pend      <= w_pend_d;
      r_insvc     <= w_insvc_d;
      r_irq       <= w_irq_d;
      r_rsp_valid <= req_valid;
      r_rsp_rdata <= w_rd ? w_rdata : '0;
      if (w_wr && req_addr == A_EN)   r_en   <= req_wdata[NUM_SRC-1:0];
      if (w_wr && req_addr == A_TRIG) r_trig <= req_wdata[NUM_SRC-1:0];
    end
  end

  assign req_ready = 1'b1;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign irq       = r_irq;

endmodule

// File: tb/tb_cpu_ad48_irq_ctrl.sv
// Directed bench for cpu_ad48_irq_ctrl; responses are checked against a queue of
// expected read data filled as each request is driven.
module tb_cpu_ad48_irq_ctrl;
  localparam int NS = 8, NL = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [NS-1:0] src_i;
  logic          req_valid, req_we;
  logic [2:0]    req_addr;
  logic [47:0]   req_wdata;
  logic          req_ready, rsp_valid;
  logic [47:0]   rsp_rdata;
  logic [NL-1:0] irq;

  cpu_ad48_irq_ctrl #(.NUM_SRC(NS), .IRQ_LINES(NL)) dut (
    .clk(clk), .resetn(resetn), .src_i(src_i),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_fail = 0, n_tot = 0;
  logic [47:0] exp_q[$];
  string       tag_q[$];

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One request; expected read data is queued, then popped when the response appears.
  task automatic bus(input logic we, input logic [2:0] a, input logic [47:0] d,
                     input logic [47:0] exp, input string tag);
    logic [47:0] e;
    string t;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    exp_q.push_back(we ? 48'h0 : exp);
    tag_q.push_back(tag);
    tick();
    req_valid = 1'b0;
    chk({tag, "_vld"}, 48'(rsp_valid), 48'h1);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, rsp_rdata, e);
  endtask

  task automatic rd(input logic [2:0] a, input logic [47:0] exp, input string tag);
    bus(1'b0, a, 48'h0, exp, tag);
  endtask

  task automatic wr(input logic [2:0] a, input logic [47:0] d, input string tag);
    bus(1'b1, a, d, 48'h0, tag);
  endtask

  initial begin
    resetn = 1'b0; src_i = '0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    tick(); tick();
    chk("rst_irq", 48'(irq), 48'h0);
    chk("rst_rspv", 48'(rsp_valid), 48'h0);
    chk("rst_rdata", rsp_rdata, 48'h0);
    chk("ready", 48'(req_ready), 48'h1);
    resetn = 1'b1;
    tick();

    // Edge latency
    wr(3'd1, 48'h01, "wr_en1");
    wr(3'd2, 48'h01, "wr_trig1");
    tick();
    chk("idle_rspv", 48'(rsp_valid), 48'h0);
    src_i = 8'h01; tick();
    src_i = 8'h00;
    chk("lat_irq_k", 48'(irq), 48'h0);
    tick();
    chk("lat_irq_k1", 48'(irq), 48'h1);
    rd(3'd0, 48'h01, "lat_pend");

    // Claim / complete
    rd(3'd3, 48'h1, "claim0");
    rd(3'd4, 48'h01, "insvc_after_claim");
    chk("irq_drop", 48'(irq), 48'h0);
    rd(3'd0, 48'h00, "pend_after_claim");
    wr(3'd3, 48'h1, "complete1");
    rd(3'd4, 48'h00, "insvc_after_cmp");
    chk("irq_stays0", 48'(irq), 48'h0);

    // Priority and routing
    wr(3'd1, 48'hFF, "wr_enFF");
    wr(3'd2, 48'hFF, "wr_trigFF");
    src_i = 8'h44; tick();
    src_i = 8'h00; tick();
    chk("route_irq", 48'(irq), 48'h4);
    rd(3'd3, 48'h3, "claim_a");
    rd(3'd3, 48'h7, "claim_b");
    rd(3'd3, 48'h0, "claim_none");
    wr(3'd3, 48'h5, "cmp_not_insvc");
    rd(3'd4, 48'h44, "insvc_44");
    wr(3'd3, 48'h9, "cmp_oob");
    wr(3'd3, 48'h0, "cmp_zero");
    rd(3'd4, 48'h44, "insvc_still44");
    wr(3'd3, 48'h3, "cmp3");
    wr(3'd3, 48'h7, "cmp7");
    rd(3'd4, 48'h00, "insvc_clr");

    // Level source
    wr(3'd2, 48'h00, "wr_trig0");
    wr(3'd1, 48'h02, "wr_en02");
    src_i = 8'h02; tick(); tick();
    chk("lvl_irq", 48'(irq), 48'h2);
    rd(3'd3, 48'h2, "lvl_claim");
    rd(3'd0, 48'h02, "lvl_pend_kept");
    chk("lvl_irq_insvc", 48'(irq), 48'h0);
    wr(3'd3, 48'h2, "lvl_cmp");
    chk("lvl_irq_cmp0", 48'(irq), 48'h0);
    tick();
    chk("lvl_reassert", 48'(irq), 48'h2);
    src_i = 8'h00;
    wr(3'd1, 48'h00, "wr_en0");

    // Collision and SWSET
    wr(3'd2, 48'hFF, "wr_trigFF2");
    wr(3'd1, 48'h01, "wr_en01");
    src_i = 8'h01; tick();
    src_i = 8'h00; tick();
    src_i = 8'h01;
    rd(3'd3, 48'h1, "coll_claim");
    src_i = 8'h00;
    rd(3'd0, 48'h01, "coll_pend");
    rd(3'd4, 48'h01, "coll_insvc");
    wr(3'd3, 48'h1, "coll_cmp");
    wr(3'd5, 48'h10, "swset10");
    rd(3'd0, 48'h11, "swset_pend");
    wr(3'd2, 48'h7F, "wr_trig7F");
    rd(3'd2, 48'h7F, "trig_rb");
    wr(3'd5, 48'h80, "swset_lvl");
    rd(3'd0, 48'h11, "swset_lvl_pend");
    rd(3'd6, 48'h0, "unmapped");
    rd(3'd5, 48'h0, "swset_rd0");

    // Reset mid-operation
    rd(3'd3, 48'h1, "pre_rst_claim");
    src_i = 8'h02;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3; resetn = 1'b0;
    tick();
    req_valid = 1'b0; resetn = 1'b1;
    chk("mid_rst_rspv", 48'(rsp_valid), 48'h0);
    chk("mid_rst_rdata", rsp_rdata, 48'h0);
    chk("mid_rst_irq", 48'(irq), 48'h0);
    rd(3'd0, 48'h00, "post_rst_pend0");
    rd(3'd0, 48'h02, "post_rst_repend");
    rd(3'd1, 48'h00, "post_rst_en");
    rd(3'd2, 48'h00, "post_rst_trig");
    rd(3'd4, 48'h00, "post_rst_insvc");
    src_i = 8'h00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
